// File: rtl/run_sequencer.sv
// Run controller: loads operands into core memory, launches the core, times it and checks its product.
// Optional watchdog enabled by defining RUN_SEQ_TIMEOUT_EN.
module run_sequencer #(
    parameter int W        = 16,
    parameter int OP_BASE  = 1,
    parameter int RES_BASE = 5,
    parameter int INIT_CYC = 2,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 100000
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             go,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic             core_start,
    input  logic             core_halt,
    output logic [7:0]       mem_addr,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_ct,
    output logic [2*W-1:0]   dut_result
);

    localparam int NB = W / 4;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_FETCH, S_CHECK, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      idx;
    logic [PW-1:0]    shreg;
    logic [PW-1:0]    res_nxt;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    prod;
    logic [W-1:0]     mplier;
    logic [5:0]       mcnt;
    logic             neg;
    logic             rd_vld;
    logic             mul_done;
    logic             start_go;
    logic             last_byte;
    logic             last_init;
    logic             to_hit;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    assign start_go  = (state == S_IDLE) && go;
    assign last_byte = (idx == 16'(NB - 1));
    assign last_init = (idx == 16'(INIT_CYC - 1));
    assign cnt_inc   = (&cycle_ct) ? cycle_ct : cycle_ct + 1'b1;
    assign mul_done  = (mcnt == 6'd0);
    assign prod      = neg ? -acc : acc;
    assign res_nxt   = rd_vld ? {dut_result[PW-9:0], mem_rdata} : dut_result;

`ifdef RUN_SEQ_TIMEOUT_EN
    assign to_hit = !core_halt && (cnt_inc == CNT_W'(TIMEOUT));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        core_start = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'd0;
        mem_wdata  = 8'd0;
        unique case (state)
            S_IDLE: begin
                core_start = 1'b1;
                if (go) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                mem_we    = 1'b1;
                mem_addr  = 8'(OP_BASE) + idx[7:0];
                mem_wdata = shreg[PW-1 -: 8];
                if (last_byte) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                if (last_init) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_halt)   state_nxt = S_FETCH;
                else if (to_hit) state_nxt = S_DONE;
            end
            S_FETCH: begin
                mem_addr = 8'(RES_BASE) + idx[7:0];
                if (last_byte) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (mul_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                core_start = timed_out;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // idx restarts at every state change and counts cycles within a state
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            shreg      <= '0;
            rd_vld     <= 1'b0;
            dut_result <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timed_out  <= 1'b0;
            cycle_ct   <= '0;
        end else begin
            idx    <= (state_nxt != state) ? 16'd0 : idx + 16'd1;
            rd_vld <= (state == S_FETCH);
            if (rd_vld) dut_result <= res_nxt;
            if (start_go) begin
                shreg     <= {op_a, op_b};
                pass      <= 1'b0;
                fail      <= 1'b0;
                timed_out <= 1'b0;
                cycle_ct  <= '0;
            end else if (state == S_LOAD) begin
                shreg <= shreg << 8;
            end
            if (state == S_RUN && !core_halt) begin
                cycle_ct <= cnt_inc;
                if (to_hit) begin
                    timed_out <= 1'b1;
                    fail      <= 1'b1;
                end
            end
            if (state == S_CHECK && mul_done) begin
                pass <= (res_nxt == prod);
                fail <= (res_nxt != prod);
            end
        end
    end

    // Reference: unsigned shift-add on magnitudes, sign applied at the end
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            mcnt   <= '0;
            neg    <= 1'b0;
        end else if (start_go) begin
            mcand  <= PW'(mag(op_a));
            mplier <= mag(op_b);
            acc    <= '0;
            mcnt   <= 6'(W);
            neg    <= op_a[W-1] ^ op_b[W-1];
        end else if (!mul_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mcnt   <= mcnt - 6'd1;
        end
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

- Synthesizable on-chip run controller for the TopLevel core.
- Per run it:
  - writes two signed W-bit operands into core data memory;
  - pulses the core's start;
  - counts clock cycles until halt;
  - reads back the 2W-bit result;
  - compares it against an internally computed signed product.
- Generalises the 16-bit software-multiply check to any byte-multiple width and to back-to-back runs, with optional watchdog.
- Sits beside TopLevel and owns its start input and a spare data-memory port.

## Interface

Parameters:
- W, 16: operand width in bits; multiple of 8, range 8..32.
- OP_BASE, 1: first data-memory address of operand A; B follows, big-endian bytes.
- RES_BASE, 5: first data-memory address of the 2W-bit result, big-endian.
- INIT_CYC, 2: cycles core_start is held high.
- CNT_W, 32: cycle counter width.
- TIMEOUT, 100000: watchdog limit in run cycles.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - CLK, in, 1: system clock, rising edge.
  - reset_n, in, 1: asynchronous active-low reset.
- Control:
  - go, in, 1: start a run; sampled in IDLE only.
  - op_a, in, W: signed operand A; captured on the go cycle.
  - op_b, in, W: signed operand B; captured on the go cycle.
- Core interface:
  - core_start, out, 1: drives TopLevel start.
  - core_halt, in, 1: TopLevel halt flag.
- Data-memory port:
  - mem_addr, out, 8: byte address.
  - mem_we, out, 1: write enable.
  - mem_wdata, out, 8: write data.
  - mem_rdata, in, 8: read data, valid the cycle after mem_addr; synchronous read.
- Status:
  - busy, out, 1: run in progress.
  - done, out, 1: one-cycle pulse at run end.
  - pass, out, 1: result matched; held until next go.
  - fail, out, 1: mismatch or timeout; held until next go.
  - timed_out, out, 1: watchdog fired; held until next go.
  - cycle_ct, out, CNT_W: run-phase cycle count; held until next go.
  - dut_result, out, 2W: value read back from the core.

## Operation

States and transitions:
- IDLE: wait for go.
  - On go: capture operands, clear pass/fail/timed_out/cycle_ct.
  - Next state LOAD.
- LOAD: one byte write per cycle, W/4 cycles.
  - Addresses OP_BASE..OP_BASE+W/4-1, order A MSB..LSB then B MSB..LSB.
  - Next state LAUNCH.
- LAUNCH: core_start=1 for INIT_CYC cycles, then 0.
  - Next state RUN.
- RUN: cycle_ct increments each cycle while core_halt=0.
  - core_halt=1 is sampled on a rising edge; that cycle is not counted.
  - Next state FETCH.
- FETCH: issue W/4 reads at RES_BASE upward.
  - Assemble dut_result MSB-first.
  - Next state CHECK.
- CHECK: wait until the multiplier is finished.
  - pass = (dut_result == expected); fail = !pass.
  - Next state DONE.
- DONE: done=1 for one cycle.
  - Next state IDLE.

Reference multiplier:
- Sequential shift-add on operand magnitudes, W iterations.
- Starts on the go cycle.
- Result negated when sign(op_a) != sign(op_b).
- Exact 2W-bit two's-complement product; for W=16, -32768 * -32768 = 0x4000_0000.

Boundary conditions:
- go while busy is ignored.
- core_halt high already on entry to RUN: cycle_ct=0, go straight to FETCH.
- cycle_ct saturates at all-ones and does not wrap.
- Memory address wrap mod 256 is permitted.
- Reset mid-run:
  - All state returns to IDLE.
  - core_start=1, so the core is held in init.
  - All status outputs return to 0.

## Timing

Reset values:
- core_start=1.
- busy, done, pass, fail, timed_out, mem_we = 0.
- cycle_ct=0, dut_result=0, mem_addr=0, mem_wdata=0.

IDLE behaviour: core_start=1 whenever in IDLE.

Cycle-level timing:
- busy rises the cycle after go is sampled and falls with done.
- Latency go -> done = 1 + W/4 + INIT_CYC + run_cycles + W/4 + 1 + CHECK wait + 1.
  - CHECK wait is 0 when the multiplier has already finished.
- pass/fail become valid in the done cycle.

## Configuration

- RUN_SEQ_TIMEOUT_EN defined:
  - In RUN, reaching cycle_ct == TIMEOUT without core_halt sets timed_out=1 and fail=1.
  - FETCH is skipped; go to DONE.
  - core_start is reasserted to freeze the core.
- RUN_SEQ_TIMEOUT_EN not defined:
  - RUN waits indefinitely.
  - timed_out is tied to 0.

## Test plan

- Reset: reset_n low mid-RUN -> all outputs at their reset values within the same cycle, core_start=1, state IDLE.
- Basic run, W=16, A=3, B=-5, core stub writes 0xFFFF_FFF1 and halts after 40 cycles:
  - memory bytes 1..4 = 00 03 FF FB;
  - pass=1, cycle_ct=40, done pulse exactly once.
- Mismatch, A=-32768, B=-32768, stub writes 0xC000_0000:
  - fail=1, dut_result=0xC000_0000, pass=0.
- Corner, W=8, A=-128, B=127, correct stub result 0xC080:
  - pass=1, only 2 operand writes and 2 result reads.
- Immediate halt: stub holds halt on entry to RUN -> cycle_ct=0, then FETCH.
- Timeout with RUN_SEQ_TIMEOUT_EN, TIMEOUT=50, stub never halts:
  - timed_out=1, fail=1, done at run cycle 50, no reads issued.
  - Without the macro: still busy after 1000 cycles.
- go asserted during RUN -> ignored; operands unchanged; single done.
